// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-framed register bank sitting behind spi_slave.
// Frames transactions on synchronised CS/SCLK, commits 40-bit write frames into
// control words, serves reads, and clears control words if the host goes silent.
module spi_reg_bank #(
  parameter int unsigned N_RO        = 4,
  parameter int unsigned N_RW        = 8,
  parameter logic [31:0] ID_WORD     = 32'hA11C0001,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                SPI_CS,
  input  logic                SPI_CLK,
  input  logic [7:0]          Data_Addr,
  input  logic [31:0]         Data_Read,
  output logic [31:0]         Data_Write,
  input  logic [32*N_RO-1:0]  Status_In,
  output logic [32*N_RW-1:0]  Ctrl_Out,
  output logic                Wr_Strobe,
  output logic [5:0]          Wr_Index,
  output logic                Wdog_Expired
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned ERR_W     = 16;
  localparam int unsigned WDOG_W    = 32;
  localparam int unsigned RW_BASE_I = 64;

  localparam logic [CNT_W-1:0]  FRAME_BITS  = CNT_W'(40);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [6:0]        RW_BASE     = 7'(RW_BASE_I);
  localparam logic [6:0]        RW_END      = 7'(RW_BASE_I + N_RW);
  localparam logic [6:0]        IDX_TX      = 7'h7E;
  localparam logic [6:0]        IDX_ERR     = 7'h7F;
  localparam logic [WDOG_W-1:0] WDOG_RELOAD = WDOG_W'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COMMIT
  } state_t;

  state_t state;
  state_t state_next;

  // [0] first sync flop, [1] synchronised level, [2] previous synchronised level
  logic [2:0] cs_pipe;
  logic [2:0] sclk_pipe;
  logic       cs_fall;
  logic       cs_rise;
  logic       sclk_rise;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_count;
  logic [ERR_W-1:0]  err_count;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [DATA_W-1:0] ctrl [N_RW];

  logic [6:0]        addr_idx;
  logic              commit;
  logic              len_ok;
  logic              rw_hit;
  logic              wr_valid;
  logic              wr_err;
  logic [5:0]        wr_idx;
  logic              wdog_fire;
  logic [DATA_W-1:0] rd_data;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cs_pipe   <= 3'b111;
      sclk_pipe <= 3'b000;
    end else begin
      cs_pipe   <= {cs_pipe[1:0], SPI_CS};
      sclk_pipe <= {sclk_pipe[1:0], SPI_CLK};
    end
  end

  assign cs_fall   = cs_pipe[2] & ~cs_pipe[1];
  assign cs_rise   = ~cs_pipe[2] & cs_pipe[1];
  assign sclk_rise = ~sclk_pipe[2] & sclk_pipe[1];

  // Frame FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame FSM next-state: CS low opens a frame, CS high closes it for one commit cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (cs_fall) state_next = S_ACTIVE;
      S_ACTIVE: if (cs_rise) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Bit counter: cleared at frame start, saturating count of SCLK rising edges
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt <= '0;
    end else if ((state == S_IDLE) && cs_fall) begin
      bit_cnt <= '0;
    end else if ((state == S_ACTIVE) && sclk_rise && (bit_cnt != CNT_MAX)) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Commit decode: classify the closing frame as valid write, error, or no-op read
  always_comb begin
    addr_idx  = Data_Addr[6:0];
    commit    = (state == S_COMMIT);
    len_ok    = (bit_cnt == FRAME_BITS);
    rw_hit    = (addr_idx >= RW_BASE) && (addr_idx < RW_END);
    wr_valid  = commit && len_ok && Data_Addr[7] && rw_hit;
    wr_err    = commit && (!len_ok || (Data_Addr[7] && !rw_hit));
    wr_idx    = 6'(addr_idx - RW_BASE);
    wdog_fire = (wdog_cnt == WDOG_W'(1)) && !wr_valid;
  end

  // Transaction and error counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_count  <= '0;
      err_count <= '0;
    end else begin
      if (commit) begin
        tx_count <= tx_count + DATA_W'(1);
      end
      if (wr_err && (err_count != ERR_MAX)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  // Watchdog down-counter; a zero reload value keeps it parked at zero
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wdog_cnt <= WDOG_RELOAD;
    end else if (wr_valid) begin
      wdog_cnt <= WDOG_RELOAD;
    end else if (wdog_cnt != '0) begin
      wdog_cnt <= wdog_cnt - WDOG_W'(1);
    end
  end

  // Control words, write strobe/index and expiry flag; a valid write beats expiry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned k = 0; k < N_RW; k++) begin
        ctrl[k] <= '0;
      end
      Wr_Strobe    <= 1'b0;
      Wr_Index     <= '0;
      Wdog_Expired <= 1'b0;
    end else begin
      Wr_Strobe <= wr_valid;
      if (wr_valid) begin
        for (int unsigned k = 0; k < N_RW; k++) begin
          if (wr_idx == 6'(k)) begin
            ctrl[k] <= Data_Read;
          end
        end
        Wr_Index     <= wr_idx;
        Wdog_Expired <= 1'b0;
      end else if (wdog_fire) begin
        for (int unsigned k = 0; k < N_RW; k++) begin
          ctrl[k] <= '0;
        end
        Wdog_Expired <= 1'b1;
      end
    end
  end

  // Flatten control words onto the output bus
  always_comb begin
    Ctrl_Out = '0;
    for (int unsigned k = 0; k < N_RW; k++) begin
      Ctrl_Out[32*k +: 32] = ctrl[k];
    end
  end

  // Read map decode for the currently addressed index
  always_comb begin
    rd_data = '0;
    if (addr_idx == 7'h00) begin
      rd_data = ID_WORD;
    end
    for (int unsigned k = 0; k < N_RO; k++) begin
      if (addr_idx == 7'(k + 1)) begin
        rd_data = Status_In[32*k +: 32];
      end
    end
    for (int unsigned k = 0; k < N_RW; k++) begin
      if (addr_idx == 7'(RW_BASE_I + k)) begin
        rd_data = ctrl[k];
      end
    end
    if (addr_idx == IDX_TX) begin
      rd_data = tx_count;
    end
    if (addr_idx == IDX_ERR) begin
      rd_data = {16'b0, err_count};
    end
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_Write <= '0;
    end else begin
      Data_Write <= rd_data;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized frames against a cycle-indexed reference model.
module tb_spi_reg_bank;

  localparam int N_RO = 4;
  localparam int N_RW = 8;
  localparam int W    = 600;
  localparam logic [31:0] ID = 32'hA11C0001;

  logic                clk = 1'b0;
  logic                Reset;
  logic                SPI_CS;
  logic                SPI_CLK;
  logic [7:0]          Data_Addr;
  logic [31:0]         Data_Read;
  logic [31:0]         Data_Write;
  logic [32*N_RO-1:0]  Status_In;
  logic [32*N_RW-1:0]  Ctrl_Out;
  logic                Wr_Strobe;
  logic [5:0]          Wr_Index;
  logic                Wdog_Expired;

  logic [31:0] status_w [N_RO];
  logic [31:0] mctrl [N_RW];
  logic [31:0] tx_m;
  logic [15:0] err_m;
  logic [5:0]  widx_m;
  int          total;
  int          bad;
  int          cyc;
  int          last_reload;

  spi_reg_bank #(
    .N_RO(N_RO), .N_RW(N_RW), .ID_WORD(ID), .WDOG_CYCLES(W)
  ) dut (
    .Clk(clk), .Reset(Reset), .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK),
    .Data_Addr(Data_Addr), .Data_Read(Data_Read), .Data_Write(Data_Write),
    .Status_In(Status_In), .Ctrl_Out(Ctrl_Out), .Wr_Strobe(Wr_Strobe),
    .Wr_Index(Wr_Index), .Wdog_Expired(Wdog_Expired)
  );

  always #5 clk = ~clk;

  always_comb begin
    Status_In = '0;
    for (int k = 0; k < N_RO; k++) Status_In[32*k +: 32] = status_w[k];
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Edge index cyc: outputs sampled 1 time unit after that edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Watchdog expiry becomes visible WDOG cycles after the last reload edge
  function automatic logic expired_at(input int t);
    return t >= last_reload + W;
  endfunction

  function automatic logic [31:0] ctrl_at(input int k, input int t);
    return expired_at(t) ? 32'h0 : mctrl[k];
  endfunction

  function automatic logic [31:0] model_rd(input logic [6:0] idx, input int t);
    int i;
    i = int'(idx);
    if (i == 0) return ID;
    if (i <= N_RO) return status_w[i-1];
    if (i >= 64 && i < 64 + N_RW) return ctrl_at(i - 64, t);
    if (i == 126) return tx_m;
    if (i == 127) return {16'h0, err_m};
    return 32'h0;
  endfunction

  function automatic logic [32*N_RW-1:0] model_ctrl_bus(input int t);
    logic [32*N_RW-1:0] v;
    v = '0;
    for (int k = 0; k < N_RW; k++) v[32*k +: 32] = ctrl_at(k, t);
    return v;
  endfunction

  task automatic model_reset();
    tx_m = 0;
    err_m = 0;
    widx_m = 0;
    for (int k = 0; k < N_RW; k++) mctrl[k] = 0;
    last_reload = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dw"}, 256'(Data_Write), 256'(0));
    chk({tag, "_ctrl"}, 256'(Ctrl_Out), 256'(0));
    chk({tag, "_strobe"}, 256'(Wr_Strobe), 256'(0));
    chk({tag, "_widx"}, 256'(Wr_Index), 256'(0));
    chk({tag, "_wdog"}, 256'(Wdog_Expired), 256'(0));
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    SPI_CS = 1'b1;
    SPI_CLK = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    model_reset();
    Reset = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [6:0] idx);
    Data_Addr = {1'b0, idx};
    tick();
    tick();
    chk(tag, 256'(Data_Write), 256'(model_rd(idx, cyc - 1)));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ctrl"}, 256'(Ctrl_Out), 256'(model_ctrl_bus(cyc)));
    chk({tag, "_wdog"}, 256'(Wdog_Expired), 256'(expired_at(cyc)));
  endtask

  // One SPI frame with nbits clock pulses; CS rise at edge n commits at edge n+4
  task automatic frame(input logic [7:0] addr, input logic [31:0] data, input int nbits);
    logic [6:0] idx;
    logic       in_rng;
    logic       valid;
    idx = addr[6:0];
    in_rng = (int'(idx) >= 64) && (int'(idx) < 64 + N_RW);
    valid = (nbits == 40) && addr[7] && in_rng;
    Data_Addr = addr;
    Data_Read = data;
    SPI_CS = 1'b0;
    repeat (4) tick();
    for (int b = 0; b < nbits; b++) begin
      SPI_CLK = 1'b1;
      repeat (3) tick();
      SPI_CLK = 1'b0;
      repeat (3) tick();
    end
    SPI_CS = 1'b1;
    tx_m = tx_m + 32'd1;
    if ((nbits != 40) || (addr[7] && !in_rng)) begin
      if (err_m != 16'hFFFF) err_m = err_m + 16'd1;
    end
    repeat (3) tick();
    chk("strobe_pre", 256'(Wr_Strobe), 256'(0));
    tick();
    if (valid) begin
      if (cyc > last_reload + W) begin
        for (int k = 0; k < N_RW; k++) mctrl[k] = 0;
      end
      mctrl[int'(idx) - 64] = data;
      widx_m = 6'(int'(idx) - 64);
      last_reload = cyc;
    end
    chk("strobe", 256'(Wr_Strobe), 256'(valid));
    chk("wr_index", 256'(Wr_Index), 256'(widx_m));
    tick();
    chk("strobe_post", 256'(Wr_Strobe), 256'(0));
    repeat (2) tick();
  endtask

  function automatic int pick_bad_len();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 20;
      3: return 39;
      4: return 41;
      default: return 70;
    endcase
  endfunction

  function automatic logic [6:0] pick_read_idx();
    case ($urandom_range(0, 5))
      0: return 7'h00;
      1: return 7'($urandom_range(1, N_RO));
      2: return 7'(64 + $urandom_range(0, N_RW - 1));
      3: return 7'h7E;
      4: return 7'h7F;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    logic [7:0] a;
    int         kind;
    total = 0;
    bad = 0;
    cyc = 0;
    Data_Addr = 8'h00;
    Data_Read = 32'h0;
    for (int k = 0; k < N_RO; k++) status_w[k] = 32'h0;

    apply_reset();

    // Read frame at the ID index, then counters
    frame(8'h00, 32'h0, 40);
    read_chk("id_word", 7'h00);
    chk("id_const", 256'(Data_Write), 256'(32'hA11C0001));
    read_chk("txcount_1", 7'h7E);
    read_chk("errcount_0", 7'h7F);

    // Valid write to control word 3
    frame(8'hC3, 32'h0000_1234, 40);
    read_chk("ctrl3_rb", 7'h43);
    check_state("after_wr3");

    // Aborted write, then write to a non-control index
    frame(8'hC0, 32'hFFFF_FFFF, 20);
    read_chk("err_abort", 7'h7F);
    frame(8'h85, 32'h1111_1111, 40);
    read_chk("err_badidx", 7'h7F);
    check_state("after_errs");

    // Status readback and unmapped index
    status_w[1] = 32'hDEADBEEF;
    read_chk("status1", 7'h02);
    read_chk("unmapped", 7'h30);

    // CS glitch without clocks is an error frame
    frame(8'hC1, 32'h5, 0);
    read_chk("err_glitch", 7'h7F);

    // Randomized frames with readback through the model
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        a = 8'h80 | 8'(64 + $urandom_range(0, N_RW - 1));
        frame(a, $urandom, 40);
      end else if (kind < 7) begin
        frame(8'($urandom_range(0, 255)), $urandom, pick_bad_len());
      end else if (kind < 8) begin
        if ($urandom_range(0, 1) == 1) a = 8'h80 | 8'($urandom_range(0, 63));
        else a = 8'h80 | 8'($urandom_range(72, 127));
        frame(a, $urandom, 40);
      end else begin
        frame(8'($urandom_range(0, 127)), $urandom, 40);
      end
      for (int k = 0; k < N_RO; k++) status_w[k] = $urandom;
      read_chk("rnd_rd_a", pick_read_idx());
      read_chk("rnd_rd_b", pick_read_idx());
      check_state("rnd");
    end

    // Watchdog boundary: one cycle before and at expiry, then recovery
    frame(8'hC1, 32'hCAFE_0001, 40);
    Data_Addr = 8'h41;
    while (cyc < last_reload + W - 1) tick();
    check_state("wdog_before");
    chk("wdog_word_live", 256'(Ctrl_Out[63:32]), 256'(32'hCAFE_0001));
    tick();
    check_state("wdog_at");
    chk("wdog_flag_set", 256'(Wdog_Expired), 256'(1));
    chk("wdog_cleared", 256'(Ctrl_Out), 256'(0));
    frame(8'hC2, 32'h0000_0055, 40);
    check_state("wdog_recover");
    chk("wdog_flag_clr", 256'(Wdog_Expired), 256'(0));
    read_chk("wdog_w1_zero", 7'h41);

    // Reset in the middle of a frame discards it
    Data_Addr = 8'hC4;
    Data_Read = 32'h7777_7777;
    SPI_CS = 1'b0;
    repeat (4) tick();
    for (int b = 0; b < 10; b++) begin
      SPI_CLK = 1'b1;
      repeat (3) tick();
      SPI_CLK = 1'b0;
      repeat (3) tick();
    end
    apply_reset();
    repeat (3) tick();
    check_reset_outputs("midreset");
    frame(8'hC4, 32'h0BAD_F00D, 40);
    read_chk("post_reset_wr", 7'h44);
    read_chk("post_reset_tx", 7'h7E);
    read_chk("post_reset_err", 7'h7F);
    check_state("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
